regfile_scoreboard: RTL and testbench

Parametrised integer register file for the RISC-V core with a configurable number of combinational read ports and one write-back port. It adds same-cycle write-to-read bypass and a per-register busy scoreboard for in-flight multi-cycle producers such as loads. It sits between decode (read/issue) and write-back. It replaces the fixed 32x32 two-read-port file and exposes busy information the hazard unit consumes directly.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/rf_read_port.sv | 40 ++++
 rtl/regfile_scoreboard.sv | 124 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the integer register file with busy scoreboard.
package regfile_pkg;

    localparam int DEF_XLEN  = 32'sd32;
    localparam int DEF_NREGS = 32'sd32;
    localparam int ZERO_REG  = 32'sd0;

    // Ceiling log2, usable in parameter and port-width expressions
    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero-register handling, write-back bypass and reset gating.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            rst,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic            reg_busy,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] data,
    output logic            busy
);

    // Select stored value, forwarded write-back data, or zero
    always_comb begin
        data = '0;
        busy = 1'b0;
        if (!rst) begin
            data = '0;
            busy = 1'b0;
        end else if (addr == AW'(ZERO_REG)) begin
            data = '0;
            busy = 1'b0;
        end else if ((BYPASS != 0) && we && (wa == addr)) begin
            // The arriving write both supplies the value and retires the producer
            data = wd;
            busy = 1'b0;
        end else begin
            data = reg_data;
            busy = reg_busy;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with NRD combinational read ports, one write-back port and a busy scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREGS  = DEF_NREGS,
    parameter int AW     = clog2(NREGS),
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NRD*AW-1:0]           rd_addr,
    output logic [NRD*XLEN-1:0]         rd_data,
    output logic [NRD-1:0]              rd_busy,
    input  logic                        we,
    input  logic [AW-1:0]               wa,
    input  logic [XLEN-1:0]             wd,
    input  logic                        iss_valid,
    input  logic [AW-1:0]               iss_addr,
    output logic [clog2(NREGS+1)-1:0]   busy_cnt,
    output logic                        drained,
    output logic                        waw_err
);

    localparam int DEPTH = 32'sd1 << AW;
    localparam int CW    = clog2(NREGS + 32'sd1);

    logic [XLEN-1:0]  regs_r [1:NREGS-1];
    logic [NREGS-1:1] busy_r;
    logic [CW-1:0]    cnt_r;
    logic             drained_r;
    logic             waw_r;

    logic [XLEN-1:0]  regs_flat_s [DEPTH];
    logic [DEPTH-1:0] busy_vec_s;
    logic [DEPTH-1:0] busy_next_s;
    logic [CW-1:0]    cnt_next_s;
    logic             we_ok_s;
    logic             iss_ok_s;
    logic             same_s;
    logic             set_s;
    logic             clr_s;
    logic             waw_s;

    // Zero-extended views of storage so read addresses index without range checks
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            regs_flat_s[j] = '0;
        end
        for (int j = 1; j < NREGS; j++) begin
            regs_flat_s[j] = regs_r[j];
        end
        busy_vec_s = DEPTH'({busy_r, 1'b0});
    end

    // Qualify write-back and issue, then derive next busy state and counter delta
    always_comb begin
        we_ok_s  = we && (wa != AW'(ZERO_REG)) && (int'(wa) < NREGS);
        iss_ok_s = iss_valid && (iss_addr != AW'(ZERO_REG)) && (int'(iss_addr) < NREGS);
        same_s   = we_ok_s && iss_ok_s && (wa == iss_addr);
        set_s    = iss_ok_s && !busy_vec_s[iss_addr];
        clr_s    = we_ok_s && busy_vec_s[wa] && !same_s;
        waw_s    = iss_ok_s && busy_vec_s[iss_addr] && !same_s;
        // A new issue outranks the clear from a write to the same register
        for (int j = 0; j < DEPTH; j++) begin
            busy_next_s[j] = (iss_ok_s && (iss_addr == AW'(j))) ? 1'b1 :
                             (we_ok_s && (wa == AW'(j)))        ? 1'b0 :
                             busy_vec_s[j];
        end
        case ({set_s, clr_s})
            2'b10:   cnt_next_s = cnt_r + CW'(1);
            2'b01:   cnt_next_s = cnt_r - CW'(1);
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Architectural state, scoreboard and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 1; j < NREGS; j++) begin
                regs_r[j] <= '0;
            end
            busy_r    <= '0;
            cnt_r     <= '0;
            drained_r <= 1'b1;
            waw_r     <= 1'b0;
        end else begin
            if (we_ok_s) begin
                regs_r[wa] <= wd;
            end
            busy_r    <= busy_next_s[NREGS-1:1];
            cnt_r     <= cnt_next_s;
            drained_r <= (cnt_next_s == CW'(0));
            waw_r     <= waw_s;
        end
    end

    assign busy_cnt = cnt_r;
    assign drained  = drained_r;
    assign waw_err  = waw_r;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr_s;
        assign addr_s = rd_addr[i*AW +: AW];

        rf_read_port #(
            .XLEN   (XLEN),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_port (
            .rst      (rst),
            .addr     (addr_s),
            .reg_data (regs_flat_s[addr_s]),
            .reg_busy (busy_vec_s[addr_s]),
            .we       (we),
            .wa       (wa),
            .wd       (wd),
            .data     (rd_data[i*XLEN +: XLEN]),
            .busy     (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing and a non-bypassing instance share stimulus.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = '0;

    logic [63:0] rd_data, nb_rd_data;
    logic [1:0]  rd_busy, nb_rd_busy;
    logic [5:0]  busy_cnt, nb_busy_cnt;
    logic        drained, nb_drained;
    logic        waw_err, nb_waw_err;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .busy_cnt(busy_cnt), .drained(drained), .waw_err(waw_err)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .busy_cnt(nb_busy_cnt), .drained(nb_drained), .waw_err(nb_waw_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        iss_valid = 1'b0;
    endtask

    task automatic test_reset();
        we = 1'b1; wa = 5'd5; wd = 32'hCAFE_F00D;
        iss_valid = 1'b1; iss_addr = 5'd5;
        rd_addr = {5'd5, 5'd5};
        repeat (3) step();
        n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want %h", rd_data, 64'h0); end
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_rd_busy got %b want %b", rd_busy, 2'b00); end
        n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_busy_cnt got %0d want 0", busy_cnt); end
        n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL reset_drained got %b want 1", drained); end
        n_checks++; if (waw_err !== 1'b0) begin n_fail++; $display("FAIL reset_waw got %b want 0", waw_err); end
        idle();
        rst = 1'b1;
        step();
        n_checks++; if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL post_reset_x5 got %h want 0", rd_data[31:0]); end
        n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL post_reset_cnt got %0d want 0", busy_cnt); end
    endtask

    task automatic test_write_bypass();
        we = 1'b1; wa = 5'd3; wd = 32'hDEAD_BEEF;
        rd_addr = {5'd3, 5'd3};
        #1;
        n_checks++; if (rd_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_p0 got %h want %h", rd_data[31:0], 32'hDEAD_BEEF); end
        n_checks++; if (rd_data[63:32] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_p1 got %h want %h", rd_data[63:32], 32'hDEAD_BEEF); end
        n_checks++; if (nb_rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL nobypass_before got %h want 0", nb_rd_data[31:0]); end
        step();
        idle();
        #1;
        n_checks++; if (rd_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stored_x3 got %h want %h", rd_data[31:0], 32'hDEAD_BEEF); end
        n_checks++; if (nb_rd_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL nobypass_after got %h want %h", nb_rd_data[31:0], 32'hDEAD_BEEF); end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; wa = 5'd0; wd = 32'h0000_1234;
        iss_valid = 1'b1; iss_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        #1;
        n_checks++; if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL x0_bypass got %h want 0", rd_data[31:0]); end
        step();
        idle();
        #1;
        n_checks++; if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL x0_data got %h want 0", rd_data[31:0]); end
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL x0_busy got %b want 00", rd_busy); end
        n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL x0_cnt got %0d want 0", busy_cnt); end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_addr = 5'd7;
        rd_addr = {5'd7, 5'd0};
        #1;
        n_checks++; if (rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL x7_busy_early got %b want 0", rd_busy[1]); end
        step();
        idle();
        #1;
        n_checks++; if (rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL x7_busy got %b want 1", rd_busy[1]); end
        n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL x7_cnt got %0d want 1", busy_cnt); end
        n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL x7_drained got %b want 0", drained); end
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0055;
        #1;
        n_checks++; if (rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL x7_clear_bypass got %b want 0", rd_busy[1]); end
        n_checks++; if (rd_data[63:32] !== 32'h55) begin n_fail++; $display("FAIL x7_data_bypass got %h want 55", rd_data[63:32]); end
        n_checks++; if (nb_rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL x7_nb_busy got %b want 1", nb_rd_busy[1]); end
        step();
        idle();
        #1;
        n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL x7_cnt_after got %0d want 0", busy_cnt); end
        n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL x7_drained_after got %b want 1", drained); end
        n_checks++; if (nb_rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL x7_nb_busy_after got %b want 0", nb_rd_busy[1]); end
    endtask

    task automatic test_simultaneous();
        we = 1'b1; wa = 5'd9; wd = 32'h0000_00AA;
        iss_valid = 1'b1; iss_addr = 5'd9;
        rd_addr = {5'd0, 5'd9};
        step();
        idle();
        #1;
        n_checks++; if (rd_data[31:0] !== 32'hAA) begin n_fail++; $display("FAIL x9_data got %h want aa", rd_data[31:0]); end
        n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL x9_busy got %b want 1", rd_busy[0]); end
        n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL x9_cnt got %0d want 1", busy_cnt); end
        n_checks++; if (waw_err !== 1'b0) begin n_fail++; $display("FAIL x9_no_waw got %b want 0", waw_err); end
        iss_valid = 1'b1; iss_addr = 5'd9;
        step();
        idle();
        #1;
        n_checks++; if (waw_err !== 1'b1) begin n_fail++; $display("FAIL waw_pulse got %b want 1", waw_err); end
        n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL waw_cnt got %0d want 1", busy_cnt); end
        step();
        n_checks++; if (waw_err !== 1'b0) begin n_fail++; $display("FAIL waw_one_cycle got %b want 0", waw_err); end
        // Issue x4 while retiring x9: net count change is zero
        we = 1'b1; wa = 5'd9; wd = 32'h0000_00BB;
        iss_valid = 1'b1; iss_addr = 5'd4;
        step();
        idle();
        #1;
        n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL swap_cnt got %0d want 1", busy_cnt); end
        n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL swap_x9_busy got %b want 0", rd_busy[0]); end
        we = 1'b1; wa = 5'd4; wd = 32'h0;
        step();
        idle();
        #1;
        n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL swap_clear_cnt got %0d want 0", busy_cnt); end
    endtask

    task automatic test_counter_range();
        for (int r = 1; r < 32; r++) begin
            iss_valid = 1'b1; iss_addr = 5'(r);
            step();
        end
        idle();
        #1;
        n_checks++; if (busy_cnt !== 6'd31) begin n_fail++; $display("FAIL full_cnt got %0d want 31", busy_cnt); end
        n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL full_drained got %b want 0", drained); end
        n_checks++; if (waw_err !== 1'b0) begin n_fail++; $display("FAIL full_waw got %b want 0", waw_err); end
        for (int r = 1; r < 32; r++) begin
            we = 1'b1; wa = 5'(r); wd = 32'(r);
            step();
            n_checks++;
            if (busy_cnt !== 6'(31 - r)) begin n_fail++; $display("FAIL drain_cnt r=%0d got %0d want %0d", r, busy_cnt, 31 - r); end
        end
        idle();
        #1;
        n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL drain_done got %b want 1", drained); end
        rd_addr = {5'd3, 5'd31};
        #1;
        n_checks++; if (rd_data[31:0] !== 32'd31) begin n_fail++; $display("FAIL x31_data got %h want 1f", rd_data[31:0]); end
    endtask

    task automatic test_async_reset();
        for (int r = 1; r <= 10; r++) begin
            iss_valid = 1'b1; iss_addr = 5'(r);
            step();
        end
        idle();
        rd_addr = {5'd3, 5'd5};
        #1;
        n_checks++; if (busy_cnt !== 6'd10) begin n_fail++; $display("FAIL pre_reset_cnt got %0d want 10", busy_cnt); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL async_cnt got %0d want 0", busy_cnt); end
        n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL async_drained got %b want 1", drained); end
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL async_busy got %b want 00", rd_busy); end
        step();
        rst = 1'b1;
        #1;
        n_checks++; if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL async_x3 got %h want 0", rd_data[63:32]); end
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL async_busy_after got %b want 00", rd_busy); end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_zero_reg();
        test_scoreboard();
        test_simultaneous();
        test_counter_range();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
